fir_delay_line: RTL and testbench

Parametrised tap delay line for the FIR datapath, the generalised successor to the fixed 16-bit enabled register.
- Holds the last TAPS accepted input samples, DATA_W bits each.
- Shifts one position per accepted sample and presents all taps in parallel to the multiply-accumulate stage.
- Tracks fill level so downstream logic can suppress outputs until the line holds only real samples.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_tap_reg.sv | 33 +++
 rtl/fir_delay_line.sv | 77 +++++++
 tb/tb_fir_delay_line.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared FIR datapath defaults and the tap bit-offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_TAPS   = 8;

    // Bit offset of tap k inside a flattened tap bus.
    function automatic int tap_slice(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_reg.sv
`default_nettype none
// ============================================================================
// Module      : fir_tap_reg
// Description : Single delay stage: zeroed on reset or clear, updated on load.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_reg
    import fir_pkg::*;
#(
    parameter int W = FIR_DATA_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/fir_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : fir_delay_line
// Description : Parametrised tap delay line with fill tracking for the FIR MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int TAPS   = FIR_TAPS,
    parameter int CNT_W  = $clog2(TAPS + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic [DATA_W*TAPS-1:0] taps_out,
    output logic                   out_valid,
    output logic                   primed,
    output logic [CNT_W-1:0]       fill_count
);

    localparam logic [CNT_W-1:0] c_full = CNT_W'(TAPS);

    logic              w_accept;
    logic [DATA_W-1:0] w_tap [TAPS];
    logic [CNT_W-1:0]  r_fill;
    logic              r_out_valid;

    assign w_accept = enable & in_valid & ~clear & ~reset;

    // Tap 0 takes the new sample; every later tap takes its predecessor.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic [DATA_W-1:0] w_d;

        if (k == 0) begin : g_head
            assign w_d = in_data;
        end else begin : g_link
            assign w_d = w_tap[k-1];
        end

        fir_tap_reg #(
            .W (DATA_W)
        ) u_tap (
            .clock (clock),
            .reset (reset),
            .clear (clear),
            .load  (w_accept),
            .d     (w_d),
            .q     (w_tap[k])
        );

        assign taps_out[tap_slice(k, DATA_W) +: DATA_W] = w_tap[k];
    end

    // Fill level saturates at TAPS so primed stays asserted on a full line.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_fill      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept && (r_fill != c_full)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign fill_count = r_fill;
    assign primed     = (r_fill == c_full);

endmodule
`default_nettype wire

// File: tb/tb_fir_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_delay_line
// Description : Table-driven scoreboard bench for fir_delay_line (TAPS=4, W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_delay_line;

    localparam int DATA_W = 16;
    localparam int TAPS   = 4;
    localparam int CNT_W  = 3;

    typedef struct {
        logic                   rst;
        logic                   clr;
        logic                   en;
        logic                   vld;
        logic [DATA_W-1:0]      data;
        logic [DATA_W*TAPS-1:0] taps;
        logic                   ov;
        logic [CNT_W-1:0]       fill;
        logic                   pr;
    } vec_t;

    typedef struct {
        logic [DATA_W*TAPS-1:0] taps;
        logic                   ov;
        logic [CNT_W-1:0]       fill;
        logic                   pr;
    } exp_t;

    logic                   clock;
    logic                   reset;
    logic                   enable;
    logic                   clear;
    logic                   in_valid;
    logic [DATA_W-1:0]      in_data;
    logic [DATA_W*TAPS-1:0] taps_out;
    logic                   out_valid;
    logic                   primed;
    logic [CNT_W-1:0]       fill_count;

    int   checks;
    int   errors;
    exp_t sb_q [$];
    vec_t vecs [11];

    fir_delay_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .taps_out   (taps_out),
        .out_valid  (out_valid),
        .primed     (primed),
        .fill_count (fill_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, req);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic step(input int idx, input logic rst, input logic clr,
                        input logic en, input logic vld, input logic [DATA_W-1:0] data,
                        input logic [DATA_W*TAPS-1:0] e_taps, input logic e_ov,
                        input logic [CNT_W-1:0] e_fill, input logic e_pr);
        exp_t e;
        @(negedge clock);
        reset    = rst;
        clear    = clr;
        enable   = en;
        in_valid = vld;
        in_data  = data;
        e.taps = e_taps;
        e.ov   = e_ov;
        e.fill = e_fill;
        e.pr   = e_pr;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step %0d: queue empty, expected 1 entry", idx);
        end else begin
            e = sb_q.pop_front();
            chk("taps_out",   idx, 64'(taps_out),   64'(e.taps));
            chk("out_valid",  idx, 64'(out_valid),  64'(e.ov));
            chk("fill_count", idx, 64'(fill_count), 64'(e.fill));
            chk("primed",     idx, 64'(primed),     64'(e.pr));
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic clr, input logic en,
                                input logic vld, input logic [15:0] data,
                                input logic [63:0] taps, input logic ov,
                                input logic [2:0] fill, input logic pr);
        vec_t v;
        v.rst = rst; v.clr = clr; v.en = en; v.vld = vld; v.data = data;
        v.taps = taps; v.ov = ov; v.fill = fill; v.pr = pr;
        return v;
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        clear    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset, fill, stall, saturate, idle; taps listed {tap3,tap2,tap1,tap0}.
        vecs[0]  = mk(1, 0, 1, 1, 16'hAAAA, 64'h0000_0000_0000_0000, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 16'h0000, 64'h0000_0000_0000_0000, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 16'h1234, 64'h0000_0000_0000_1234, 1, 1, 0);
        vecs[3]  = mk(0, 0, 1, 1, 16'h5678, 64'h0000_0000_1234_5678, 1, 2, 0);
        vecs[4]  = mk(0, 0, 1, 1, 16'h9ABC, 64'h0000_1234_5678_9ABC, 1, 3, 0);
        vecs[5]  = mk(0, 0, 1, 1, 16'hDEF0, 64'h1234_5678_9ABC_DEF0, 1, 4, 1);
        vecs[6]  = mk(0, 0, 0, 1, 16'hFFFF, 64'h1234_5678_9ABC_DEF0, 0, 4, 1);
        vecs[7]  = mk(0, 0, 0, 1, 16'hFFFF, 64'h1234_5678_9ABC_DEF0, 0, 4, 1);
        vecs[8]  = mk(0, 0, 0, 1, 16'hFFFF, 64'h1234_5678_9ABC_DEF0, 0, 4, 1);
        vecs[9]  = mk(0, 0, 1, 1, 16'h0001, 64'h5678_9ABC_DEF0_0001, 1, 4, 1);
        vecs[10] = mk(0, 0, 1, 0, 16'h3333, 64'h5678_9ABC_DEF0_0001, 0, 4, 1);

        foreach (vecs[i]) begin
            step(i, vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].vld, vecs[i].data,
                 vecs[i].taps, vecs[i].ov, vecs[i].fill, vecs[i].pr);
        end

        // Reset dominates a simultaneous accept on a primed line.
        step(20, 1, 0, 1, 1, 16'h4444, 64'h0, 0, 0, 0);

        // Clear mid-fill drops the concurrent sample.
        step(21, 0, 0, 1, 1, 16'h1111, 64'h0000_0000_0000_1111, 1, 1, 0);
        step(22, 0, 0, 1, 1, 16'h2222, 64'h0000_0000_1111_2222, 1, 2, 0);
        step(23, 0, 1, 1, 1, 16'h7777, 64'h0, 0, 0, 0);
        step(24, 0, 0, 0, 0, 16'h0000, 64'h0, 0, 0, 0);

        // Clear acts even with enable low.
        step(25, 0, 0, 1, 1, 16'h5555, 64'h0000_0000_0000_5555, 1, 1, 0);
        step(26, 0, 1, 0, 0, 16'h0000, 64'h0, 0, 0, 0);

        // Gapped input: out_valid pulses only after each accept.
        step(30, 0, 0, 1, 1, 16'h00AA, 64'h0000_0000_0000_00AA, 1, 1, 0);
        step(31, 0, 0, 1, 0, 16'h0000, 64'h0000_0000_0000_00AA, 0, 1, 0);
        step(32, 0, 0, 1, 0, 16'h0000, 64'h0000_0000_0000_00AA, 0, 1, 0);
        step(33, 0, 0, 1, 1, 16'h00BB, 64'h0000_0000_00AA_00BB, 1, 2, 0);
        step(34, 0, 0, 1, 0, 16'h0000, 64'h0000_0000_00AA_00BB, 0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
